// File: rtl/router_dst_fifo.sv
// router_dst_fifo
//   First-word-fall-through destination FIFO for a packet router. Each entry
//   stores {sop, data}. An optional idle-read timeout flushes the FIFO when
//   the destination leaves valid data unread for TIMEOUT consecutive cycles.
//
//   Build option: define ROUTER_DST_TIMEOUT_EN to include the timeout timer and
//   flush logic. When undefined, soft_reset is tied low and TIMEOUT is unused.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : synchronous active-high reset
//   we         : write request
//   data_in    : write data (DATA_WIDTH)
//   sop_in     : data_in is a packet header byte
//   full       : FIFO holds DEPTH entries
//   read_enb   : destination read request
//   vld_out    : head entry valid (FIFO not empty)
//   data_out   : head entry data, 0 when empty
//   sop_out    : head entry is a header byte, 0 when empty
//   count      : current occupancy ($clog2(DEPTH)+1 bits)
//   soft_reset : one-cycle pulse following a timeout flush
module router_dst_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     sop_in,
  output logic                     full,
  input  logic                     read_enb,
  output logic                     vld_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     sop_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("router_dst_fifo: DATA_WIDTH must be >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("router_dst_fifo: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("router_dst_fifo: TIMEOUT must be >= 2");
  end

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [DATA_WIDTH:0] head;
  logic                wr_acc;
  logic                rd_acc;
  logic                flush;

  assign vld_out = (count != '0);
  assign full    = (count == CW'(DEPTH));

  // Flush wins over a same-cycle write; a flush only happens on an idle
  // cycle, so no read can coincide with it.
  assign wr_acc = we & ~full & ~flush;
  assign rd_acc = read_enb & vld_out;

  assign head     = mem[rd_ptr];
  assign data_out = vld_out ? head[DATA_WIDTH-1:0] : '0;
  assign sop_out  = vld_out ? head[DATA_WIDTH] : 1'b0;

`ifdef ROUTER_DST_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer;
  logic          idle;

  assign idle  = vld_out & ~read_enb;
  // timer holds the number of idle cycles already completed, so this edge
  // completes the TIMEOUT-th one when it reads TIMEOUT-1.
  assign flush = idle & (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      timer      <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= flush;
      if (!idle || flush) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
`else
  assign flush      = 1'b0;
  assign soft_reset = 1'b0;
`endif

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= {sop_in, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_router_dst_fifo.sv
// tb_router_dst_fifo
//   Self-checking bench for router_dst_fifo. A queue-based reference model
//   tracks FIFO contents and the idle-read timeout; every cycle all outputs
//   are compared against it. Directed sequences cover the listed scenarios,
//   followed by randomized traffic phases. Honors ROUTER_DST_TIMEOUT_EN.
module tb_router_dst_fifo;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;

  logic          clock;
  logic          reset;
  logic          we;
  logic [DW-1:0] data_in;
  logic          sop_in;
  logic          full;
  logic          read_enb;
  logic          vld_out;
  logic [DW-1:0] data_out;
  logic          sop_out;
  logic [4:0]    count;
  logic          soft_reset;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  router_dst_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .we        (we),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .full      (full),
    .read_enb  (read_enb),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .count     (count),
    .soft_reset(soft_reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [DW:0] q[$];
  int          idle_cycles = 0;
  logic        m_soft_reset = 1'b0;
  int          n_flushes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic w, input logic [DW-1:0] d, input logic s,
                            input logic r, input logic rs);
    logic m_vld;
    logic m_full;
    logic m_flush;
    m_vld   = (q.size() != 0);
    m_full  = (q.size() == DEPTH);
    m_flush = 1'b0;
    if (rs) begin
      q.delete();
      idle_cycles  = 0;
      m_soft_reset = 1'b0;
    end else begin
`ifdef ROUTER_DST_TIMEOUT_EN
      if (m_vld && !r) begin
        idle_cycles++;
        if (idle_cycles == TIMEOUT) m_flush = 1'b1;
      end else begin
        idle_cycles = 0;
      end
`endif
      if (m_flush) begin
        q.delete();
        idle_cycles  = 0;
        m_soft_reset = 1'b1;
        n_flushes++;
      end else begin
        m_soft_reset = 1'b0;
        if (r && m_vld) void'(q.pop_front());
        if (w && !m_full) q.push_back({s, d});
      end
    end
  endtask

  task automatic check_outputs();
    logic [DW:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    check("vld_out",    32'(vld_out),    32'(q.size() != 0));
    check("full",       32'(full),       32'(q.size() == DEPTH));
    check("count",      32'(count),      32'(q.size()));
    check("data_out",   32'(data_out),   32'(h[DW-1:0]));
    check("sop_out",    32'(sop_out),    32'(h[DW]));
    check("soft_reset", 32'(soft_reset), 32'(m_soft_reset));
  endtask

  // One clock: drive inputs (called just after a falling edge), update the
  // model at the rising edge, compare 1 time unit later.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic s,
                       input logic r, input logic rs);
    we = w; data_in = d; sop_in = s; read_enb = r; reset = rs;
    @(posedge clock);
    model_step(w, d, s, r, rs);
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned wp;
    int unsigned rp;
    we = 1'b0; data_in = '0; sop_in = 1'b0; read_enb = 1'b0; reset = 1'b1;
    @(negedge clock);

    // Reset state
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Header plus two payload bytes, then drain
    cycle(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    check("seq_count3", 32'(count), 32'd3);
    check("seq_head", 32'({sop_out, data_out}), 32'h181);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("seq_empty", 32'(vld_out), 32'd0);

    // Overfill by one, then drain in order
    for (int i = 1; i <= 17; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      check("ovf_order", 32'(data_out), 32'(i));
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end

    // Full with simultaneous write+read, three fill/drain rounds
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h40 + i + k), 1'(i == 0), 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
      check("full_rw_count", 32'(count), 32'd15);
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end

    // Idle with data stored: flush when the timeout build is enabled
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'hA0 + i), 1'(i == 0), 1'b0, 1'b0);
    idle(TIMEOUT + 3);
    // Reading before the limit keeps the data
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'hB0 + i), 1'(i == 0), 1'b0, 1'b0);
    idle(TIMEOUT - 5);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(TIMEOUT - 2);
    check("no_flush_count", 32'(count), 32'd3);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Continuous write without reading: write lands on the flush cycle
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    idle(100);

    // Reset with five entries and concurrent write/read
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hDD, 1'b1, 1'b1, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("rst_newhead", 32'({sop_out, data_out}), 32'h15A);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic phases
    for (int p = 0; p < 20; p++) begin
      wp = $urandom_range(0, 100);
      rp = (p % 4 == 3) ? 0 : $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        cycle(1'($urandom_range(0, 99) < wp), DW'($urandom), 1'($urandom),
              1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 299) == 0));
      end
    end

`ifdef ROUTER_DST_TIMEOUT_EN
    check("flush_seen", 32'(n_flushes != 0), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
